// File: rtl/pwm_timebase_ctrl_pkg.sv
// Shared PWM timebase definitions: FSM state encoding and datapath widths.
package pwm_timebase_ctrl_pkg;

  localparam int CNT_W = 16;
  localparam int CFG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: tick is high on one cycle out of every (ratio+1) while enabled.
module pwm_prescaler
  import pwm_timebase_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CFG_W-1:0] ratio,
  output logic             tick
);

  logic [CFG_W-1:0] cnt_q;
  logic [CFG_W-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == ratio);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase controller: run/drain/burst sequencing, prescaled period counter
// and shadowed configuration registers loaded at period boundaries.
module pwm_timebase_ctrl
  import pwm_timebase_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_compare1,
  input  logic [CNT_W-1:0] cfg_compare2,
  input  logic [CFG_W-1:0] cfg_functions,
  input  logic [CFG_W-1:0] cfg_prescale,
  input  logic [CFG_W-1:0] cfg_burst,
  input  logic             upd_req,
  output logic [CNT_W-1:0] count_val,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] compare1,
  output logic [CNT_W-1:0] compare2,
  output logic [CFG_W-1:0] functions,
  output logic             pwm_en,
  output logic             period_done,
  output logic             upd_ack,
  output logic             busy
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] compare1_q;
  logic [CNT_W-1:0] compare2_q;
  logic [CFG_W-1:0] functions_q;
  logic [CFG_W-1:0] prescale_q;
  logic [CFG_W-1:0] burst_q;
  logic [CFG_W-1:0] burst_cnt_q;
  logic             pending_q;
  logic             pwm_en_q;
  logic             busy_q;
  logic             period_done_q;
  logic             upd_ack_q;

  logic             tick;
  logic             period_end;
  logic             load;
  logic             burst_done;

  pwm_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .en    (state_q != ST_IDLE),
    .ratio (prescale_q),
    .tick  (tick)
  );

  assign period_end = tick && (count_q == period_q);
  assign burst_done = period_end && (burst_q != 8'd0) && (burst_cnt_q + 8'd1 == burst_q);

  // A request arriving on the period-end cycle itself is honoured at that wrap.
  assign load = (state_q == ST_IDLE) ? pending_q : (period_end && (pending_q || upd_req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      period_q      <= '0;
      compare1_q    <= '0;
      compare2_q    <= '0;
      functions_q   <= '0;
      prescale_q    <= '0;
      burst_q       <= '0;
      burst_cnt_q   <= '0;
      pending_q     <= 1'b0;
      pwm_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      period_done_q <= 1'b0;
      upd_ack_q     <= 1'b0;
    end else begin
      period_done_q <= 1'b0;
      upd_ack_q     <= 1'b0;
      pending_q     <= load ? 1'b0 : (pending_q || upd_req);

      if (load) begin
        period_q    <= cfg_period;
        compare1_q  <= cfg_compare1;
        compare2_q  <= cfg_compare2;
        functions_q <= cfg_functions;
        prescale_q  <= cfg_prescale;
        burst_q     <= cfg_burst;
        upd_ack_q   <= 1'b1;
      end

      if (state_q != ST_IDLE && tick) begin
        if (period_end) begin
          count_q       <= '0;
          period_done_q <= 1'b1;
          burst_cnt_q   <= burst_cnt_q + 8'd1;
        end else begin
          count_q <= count_q + 16'd1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            burst_cnt_q <= '0;
            pwm_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          // stop takes priority over a burst completing on the same cycle
          if (stop) begin
            state_q <= ST_DRAIN;
          end else if (burst_done) begin
            state_q  <= ST_IDLE;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (period_end) begin
            state_q  <= ST_IDLE;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pwm_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign count_val   = count_q;
  assign period      = period_q;
  assign compare1    = compare1_q;
  assign compare2    = compare2_q;
  assign functions   = functions_q;
  assign pwm_en      = pwm_en_q;
  assign period_done = period_done_q;
  assign upd_ack     = upd_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed self-checking bench for pwm_timebase_ctrl.
module tb_pwm_timebase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, upd_req;
  logic [15:0] cfg_period, cfg_compare1, cfg_compare2;
  logic [7:0]  cfg_functions, cfg_prescale, cfg_burst;
  logic [15:0] count_val, period, compare1, compare2;
  logic [7:0]  functions;
  logic        pwm_en, period_done, upd_ack, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_timebase_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_period    (cfg_period),
    .cfg_compare1  (cfg_compare1),
    .cfg_compare2  (cfg_compare2),
    .cfg_functions (cfg_functions),
    .cfg_prescale  (cfg_prescale),
    .cfg_burst     (cfg_burst),
    .upd_req       (upd_req),
    .count_val     (count_val),
    .period        (period),
    .compare1      (compare1),
    .compare2      (compare2),
    .functions     (functions),
    .pwm_en        (pwm_en),
    .period_done   (period_done),
    .upd_ack       (upd_ack),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".count"}, {16'd0, count_val}, 32'd0);
    chk({tag, ".period"}, {16'd0, period}, 32'd0);
    chk({tag, ".cmp1"}, {16'd0, compare1}, 32'd0);
    chk({tag, ".cmp2"}, {16'd0, compare2}, 32'd0);
    chk({tag, ".func"}, {24'd0, functions}, 32'd0);
    chk({tag, ".flags"}, {28'd0, pwm_en, period_done, upd_ack, busy}, 32'd0);
  endtask

  // Shadow-load from IDLE: ack appears one cycle after the request is registered.
  task automatic load_idle(input string tag, input logic [15:0] p, input logic [7:0] pre,
                           input logic [7:0] b);
    cfg_period = p; cfg_prescale = pre; cfg_burst = b;
    upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    step(1);
    chk({tag, ".ack"}, {31'd0, upd_ack}, 32'd1);
    chk({tag, ".period"}, {16'd0, period}, {16'd0, p});
    step(1);
  endtask

  task automatic start_run();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop_and_wait_idle(input string tag);
    bit seen = 1'b0;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      if (!pwm_en) seen = 1'b1;
    end
    chk({tag, ".reached_idle"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int pd_cnt;
    int ack_cnt;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; upd_req = 1'b0;
    cfg_period = 16'd0; cfg_compare1 = 16'd0; cfg_compare2 = 16'd0;
    cfg_functions = 8'd0; cfg_prescale = 8'd0; cfg_burst = 8'd0;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk_all_zero("reset");

    // S1: IDLE load, period 4, prescale 0
    cfg_period = 16'd4; cfg_prescale = 8'd0; cfg_burst = 8'd0;
    cfg_compare1 = 16'h1234; cfg_compare2 = 16'hBEEF; cfg_functions = 8'hA5;
    upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    chk("s1.ack_not_yet", {31'd0, upd_ack}, 32'd0);
    step(1);
    chk("s1.ack", {31'd0, upd_ack}, 32'd1);
    chk("s1.period", {16'd0, period}, 32'd4);
    chk("s1.cmp1", {16'd0, compare1}, 32'h1234);
    chk("s1.cmp2", {16'd0, compare2}, 32'hBEEF);
    chk("s1.func", {24'd0, functions}, 32'hA5);
    step(1);
    chk("s1.ack_pulse", {31'd0, upd_ack}, 32'd0);
    start_run();
    chk("s1.en", {30'd0, pwm_en, busy}, 32'd3);
    chk("s1.c0", {16'd0, count_val}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("s1.cnt", {16'd0, count_val}, k);
      chk("s1.no_pd", {31'd0, period_done}, 32'd0);
    end
    step(1);
    chk("s1.wrap", {16'd0, count_val}, 32'd0);
    chk("s1.pd", {31'd0, period_done}, 32'd1);
    step(1);
    chk("s1.pd_pulse", {31'd0, period_done}, 32'd0);
    chk("s1.c1", {16'd0, count_val}, 32'd1);
    stop_and_wait_idle("s1");

    // S2: prescale 2, period 1
    load_idle("s2", 16'd1, 8'd2, 8'd0);
    start_run();
    step(2);
    chk("s2.c_hold", {16'd0, count_val}, 32'd0);
    step(1);
    chk("s2.c1", {16'd0, count_val}, 32'd1);
    step(2);
    chk("s2.c1_hold", {17'd0, count_val, period_done}, 32'd2);
    step(1);
    chk("s2.wrap", {15'd0, count_val, period_done}, 32'd1);
    step(1);
    chk("s2.pd_off", {31'd0, period_done}, 32'd0);
    step(4);
    chk("s2.pd_off2", {31'd0, period_done}, 32'd0);
    step(1);
    chk("s2.pd2", {31'd0, period_done}, 32'd1);
    stop_and_wait_idle("s2");

    // S3: burst 3, period 2 -> ends after 9 cycles of counting
    load_idle("s3", 16'd2, 8'd0, 8'd3);
    start_run();
    pd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (period_done) pd_cnt++;
    end
    chk("s3.en_before_end", {31'd0, pwm_en}, 32'd1);
    step(1);
    if (period_done) pd_cnt++;
    chk("s3.idle", {30'd0, pwm_en, busy}, 32'd0);
    chk("s3.count0", {16'd0, count_val}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (period_done) pd_cnt++;
    end
    chk("s3.pd_total", pd_cnt, 32'd3);
    chk("s3.still_idle", {31'd0, pwm_en}, 32'd0);

    // S4: mid-period update 5 -> 9, with a repeated request while pending
    load_idle("s4", 16'd5, 8'd0, 8'd0);
    start_run();
    step(2);
    cfg_period = 16'd8;
    upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    chk("s4.pending_no_ack", {15'd0, period, upd_ack}, {15'd0, 16'd5, 1'b0});
    cfg_period = 16'd9;
    upd_req = 1'b1;
    ack_cnt = 0;
    step(1);
    upd_req = 1'b0;
    if (upd_ack) ack_cnt++;
    step(1);
    if (upd_ack) ack_cnt++;
    chk("s4.c5", {16'd0, count_val}, 32'd5);
    chk("s4.p5", {16'd0, period}, 32'd5);
    step(1);
    if (upd_ack) ack_cnt++;
    chk("s4.wrap_pd_ack", {29'd0, count_val == 16'd0, period_done, upd_ack}, 32'd7);
    chk("s4.p9", {16'd0, period}, 32'd9);
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (upd_ack) ack_cnt++;
    end
    chk("s4.c9", {16'd0, count_val}, 32'd9);
    step(1);
    if (upd_ack) ack_cnt++;
    chk("s4.wrap2", {15'd0, count_val, period_done}, 32'd1);
    chk("s4.single_ack", ack_cnt, 32'd1);
    stop_and_wait_idle("s4");

    // S5: stop at count 2, period 7, start ignored during DRAIN
    load_idle("s5", 16'd7, 8'd0, 8'd0);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("s5.start_stop_ignored", {31'd0, pwm_en}, 32'd0);
    start_run();
    step(2);
    chk("s5.c2", {16'd0, count_val}, 32'd2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("s5.drain", {14'd0, count_val, pwm_en, busy}, {14'd0, 16'd3, 2'b11});
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    chk("s5.c7", {14'd0, count_val, pwm_en, busy}, {14'd0, 16'd7, 2'b11});
    step(1);
    chk("s5.end", {13'd0, count_val, period_done, pwm_en, busy}, {13'd0, 16'd0, 3'b100});
    step(2);
    chk("s5.stays_idle", {31'd0, pwm_en}, 32'd0);

    // S6: reset at count 3 with a load pending
    load_idle("s6", 16'd5, 8'd0, 8'd0);
    start_run();
    step(2);
    cfg_period = 16'd12;
    upd_req = 1'b1;
    step(1);
    upd_req = 1'b0;
    chk("s6.c3", {16'd0, count_val}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("s6.async");
    step(2);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (upd_ack) ack_cnt++;
    end
    chk("s6.no_ack", ack_cnt, 32'd0);
    chk_all_zero("s6.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
